// File: rtl/dds_fm_synth.sv
// Purpose: distance-driven FM direct digital synthesiser producing 10-bit DAC samples for an R-2R ladder.
// Latency: one sample per tick (every DIV enabled cycles); a distance sample reaches mapped_tw NUM_W+2 cycles after its strobe.
// Backpressure: none; distance_valid while the mapping divider is busy is dropped, and enable=0 freezes the sample stream.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   enable                    run the tick counter and phase accumulator
//   mode                      0 sawtooth, 1 triangle, 2 square, 3 silent (mid-scale)
//   distance, distance_valid  distance sample and its one-cycle strobe
//   tw_override_en/_override  replace the mapped tuning word as the pending word
//   amplitude, amp_valid      registered DAC sample and its update pulse
//   phase_wrap                accumulator carry-out pulse
//   busy                      mapping divider running
//   tuning_word_out           tuning word currently driving the accumulator
module dds_fm_synth #(
    parameter int PHASE_W  = 13,
    parameter int AMP_W    = 10,
    parameter int DIST_W   = 12,
    parameter int DIV      = 1,
    parameter int MIN_DIST = 400,
    parameter int MAX_DIST = 2000,
    parameter int MIN_TW   = 16,
    parameter int MAX_TW   = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [DIST_W-1:0]  distance,
    input  logic               distance_valid,
    input  logic               tw_override_en,
    input  logic [PHASE_W-1:0] tw_override,
    output logic [AMP_W-1:0]   amplitude,
    output logic               amp_valid,
    output logic               phase_wrap,
    output logic               busy,
    output logic [PHASE_W-1:0] tuning_word_out
);

    localparam int NUM_W   = DIST_W + PHASE_W;
    localparam int DEN_INT = MAX_DIST - MIN_DIST;
    localparam int DEN_W   = $clog2(DEN_INT + 1);
    localparam int REM_W   = DEN_W + 1;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = $clog2(NUM_W + 1);

    localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [DIST_W-1:0]  MIN_D      = DIST_W'(MIN_DIST);
    localparam logic [DIST_W-1:0]  MAX_D      = DIST_W'(MAX_DIST);
    localparam logic [NUM_W-1:0]   TW_SPAN    = NUM_W'(MAX_TW - MIN_TW);
    localparam logic [REM_W-1:0]   DEN        = REM_W'(DEN_INT);
    localparam logic [PHASE_W-1:0] MIN_TW_W   = PHASE_W'(MIN_TW);
    localparam logic [PHASE_W-1:0] MAX_TW_W   = PHASE_W'(MAX_TW);
    localparam logic [AMP_W-1:0]   MID_AMP    = AMP_W'(1) << (AMP_W - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(NUM_W - 1);

    // ---------------------------------------------------------------
    // Sample tick and phase accumulator
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]   tick_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] active_tw;
    logic [PHASE_W-1:0] mapped_tw;
    logic [PHASE_W-1:0] pending_tw;
    logic [PHASE_W:0]   phase_sum;
    logic               tick;
    logic               carry;
    logic [AMP_W-1:0]   wave;

    assign tick       = enable && (tick_cnt == '0);
    assign phase_sum  = {1'b0, phase} + {1'b0, active_tw};
    assign carry      = phase_sum[PHASE_W];
    assign pending_tw = tw_override_en ? tw_override : mapped_tw;

    // Waveform shaping from the pre-increment phase.
    always_comb begin
        wave = MID_AMP;
        case (mode)
            2'd0: wave = phase[PHASE_W-1 -: AMP_W];
            2'd1: wave = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: AMP_W]
                                          :  phase[PHASE_W-2 -: AMP_W];
            2'd2: wave = phase[PHASE_W-1] ? '0 : '1;
            default: wave = MID_AMP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt   <= CNT_RELOAD;
            phase      <= '0;
            active_tw  <= MIN_TW_W;
            amplitude  <= '0;
            amp_valid  <= 1'b0;
            phase_wrap <= 1'b0;
        end else begin
            amp_valid  <= tick;
            phase_wrap <= tick && carry;
            if (enable) begin
                tick_cnt <= (tick_cnt == '0) ? CNT_RELOAD : tick_cnt - 1'b1;
            end
            if (tick) begin
                phase     <= phase_sum[PHASE_W-1:0];
                amplitude <= wave;
                // New words land only at a wrap so the waveform never jumps
                // mid-period; a zero word would never wrap, so it is replaced
                // unconditionally.
                if (carry || active_tw == '0) begin
                    active_tw <= pending_tw;
                end
            end
        end
    end

    assign tuning_word_out = active_tw;

    // ---------------------------------------------------------------
    // Distance-to-tuning-word mapping divider
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

    state_t            state, state_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [NUM_W-1:0]  quo;        // dividend shifts out, quotient shifts in
    logic [DEN_W-1:0]  rem;
    logic [REM_W-1:0]  trial;
    logic              q_bit;
    logic [DEN_W-1:0]  rem_next;
    logic [DIST_W-1:0] d_clamped;
    logic [NUM_W-1:0]  num_init;

    always_comb begin
        d_clamped = distance;
        if (distance < MIN_D) begin
            d_clamped = MIN_D;
        end else if (distance > MAX_D) begin
            d_clamped = MAX_D;
        end
    end

    assign num_init = NUM_W'(d_clamped - MIN_D) * TW_SPAN;
    assign trial    = {rem, quo[NUM_W-1]};
    assign q_bit    = (trial >= DEN);
    assign rem_next = q_bit ? DEN_W'(trial - DEN) : trial[DEN_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (distance_valid) state_next = S_DIVIDE;
            S_DIVIDE: if (bit_cnt == LAST_BIT) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_DIVIDE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            quo       <= '0;
            rem       <= '0;
            mapped_tw <= MIN_TW_W;
        end else begin
            case (state)
                S_IDLE: begin
                    if (distance_valid) begin
                        quo     <= num_init;
                        rem     <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_DIVIDE: begin
                    rem     <= rem_next;
                    quo     <= {quo[NUM_W-2:0], q_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_DONE: begin
                    // Nearer objects give a larger word, hence higher pitch.
                    mapped_tw <= MAX_TW_W - quo[PHASE_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_fm_synth.sv
module tb_dds_fm_synth;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] distance;
    logic        distance_valid;
    logic        tw_override_en;
    logic [12:0] tw_override;

    logic [9:0]  amplitude;
    logic        amp_valid;
    logic        phase_wrap;
    logic        busy;
    logic [12:0] tuning_word_out;

    logic [9:0]  amplitude4;
    logic        amp_valid4;
    logic        phase_wrap4;
    logic        busy4;
    logic [12:0] tuning_word_out4;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expectations pushed as each tick's stimulus is applied.
    int amp_q[$];
    int wrap_q[$];
    int m_phase;
    int m_active;

    always #5 clk = ~clk;

    dds_fm_synth u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .distance(distance), .distance_valid(distance_valid),
        .tw_override_en(tw_override_en), .tw_override(tw_override),
        .amplitude(amplitude), .amp_valid(amp_valid), .phase_wrap(phase_wrap),
        .busy(busy), .tuning_word_out(tuning_word_out)
    );

    dds_fm_synth #(.DIV(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .distance(distance), .distance_valid(distance_valid),
        .tw_override_en(tw_override_en), .tw_override(tw_override),
        .amplitude(amplitude4), .amp_valid(amp_valid4), .phase_wrap(phase_wrap4),
        .busy(busy4), .tuning_word_out(tuning_word_out4)
    );

    function automatic int wave(input int ph, input int md);
        int msb;
        int p;
        int q;
        msb = (ph >> 12) & 1;
        p   = (ph >> 3) & 1023;
        q   = (ph >> 2) & 1023;
        case (md)
            0: return p;
            1: return (msb == 1) ? 1023 - q : q;
            2: return (msb == 1) ? 0 : 1023;
            default: return 512;
        endcase
    endfunction

    // Reference model of one tick, using the inputs as currently driven.
    task automatic model_tick();
        int sum;
        sum = m_phase + m_active;
        amp_q.push_back(wave(m_phase, int'(mode)));
        wrap_q.push_back((sum >= 8192) ? 1 : 0);
        if (sum >= 8192 || m_active == 0) m_active = int'(tw_override);
        m_phase = sum % 8192;
    endtask

    task automatic wait_wrap(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (phase_wrap === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; distance = '0;
        distance_valid = 1'b0; tw_override_en = 1'b0; tw_override = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1; enable = 1'b1; tw_override_en = 1'b1; tw_override = 13'd1024;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (amplitude !== 10'd0) begin errors++; $display("FAIL reset_amp got %0d expected 0", amplitude); end
        checks++; if (amp_valid !== 1'b0) begin errors++; $display("FAIL reset_amp_valid got %b expected 0", amp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (tuning_word_out !== 13'd16) begin errors++; $display("FAIL reset_tw got %0d expected 16", tuning_word_out); end
        checks++; if (amplitude4 !== 10'd0 || busy4 !== 1'b0 || phase_wrap4 !== 1'b0 || tuning_word_out4 !== 13'd16) begin
            errors++; $display("FAIL reset_div4 got amp %0d busy %b wrap %b tw %0d expected 0 0 0 16", amplitude4, busy4, phase_wrap4, tuning_word_out4);
        end
        @(negedge clk);
        reset_n = 1'b1; tw_override_en = 1'b0; mode = 2'd0; enable = 1'b1;
        @(negedge clk);
        checks++; if (amp_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b expected 1", amp_valid); end
        checks++; if (amplitude !== 10'd0) begin errors++; $display("FAIL first_sample got %0d expected 0", amplitude); end
        m_phase = 16; m_active = 16;
    endtask

    task automatic test_sawtooth();
        bit found;
        logic [9:0] ea;
        logic       ew;
        logic [9:0] last_exp;
        tw_override_en = 1'b1; tw_override = 13'd1024;
        wait_wrap(700, found);
        checks++; if (!found) begin errors++; $display("FAIL saw_wrap_timeout got none expected wrap"); end
        checks++; if (tuning_word_out !== 13'd1024) begin errors++; $display("FAIL saw_tw got %0d expected 1024", tuning_word_out); end
        m_phase = 0; m_active = 1024; last_exp = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) begin
                enable = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    checks++; if (amp_valid !== 1'b0 || amplitude !== last_exp) begin
                        errors++; $display("FAIL hold got valid %b amp %0d expected 0 %0d", amp_valid, amplitude, last_exp);
                    end
                end
                enable = 1'b1;
            end
            model_tick();
            @(negedge clk);
            ea = 10'(amp_q.pop_front());
            ew = 1'(wrap_q.pop_front());
            last_exp = ea;
            checks++; if (amp_valid !== 1'b1) begin errors++; $display("FAIL saw_valid tick %0d got %b expected 1", i, amp_valid); end
            checks++; if (amplitude !== ea) begin errors++; $display("FAIL saw_amp tick %0d got %0d expected %0d", i, amplitude, ea); end
            checks++; if (phase_wrap !== ew) begin errors++; $display("FAIL saw_wrap tick %0d got %b expected %b", i, phase_wrap, ew); end
        end
    endtask

    task automatic test_div4();
        int cnt;
        int last;
        cnt = 0; last = -1;
        for (int i = 0; i < 40; i++) begin
            model_tick();
            @(negedge clk);
            void'(amp_q.pop_front());
            void'(wrap_q.pop_front());
            if (amp_valid4 === 1'b1) begin
                cnt++;
                if (last >= 0) begin
                    checks++; if (i - last != 4) begin errors++; $display("FAIL div4_gap got %0d expected 4", i - last); end
                end
                last = i;
            end
        end
        checks++; if (cnt != 10) begin errors++; $display("FAIL div4_count got %0d expected 10", cnt); end
    endtask

    task automatic test_override_switch();
        logic [9:0] ea;
        logic       ew;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) tw_override = 13'd2048;
            model_tick();
            @(negedge clk);
            ea = 10'(amp_q.pop_front());
            ew = 1'(wrap_q.pop_front());
            checks++; if (amplitude !== ea) begin errors++; $display("FAIL switch_amp tick %0d got %0d expected %0d", i, amplitude, ea); end
            checks++; if (phase_wrap !== ew) begin errors++; $display("FAIL switch_wrap tick %0d got %b expected %b", i, phase_wrap, ew); end
        end
        checks++; if (tuning_word_out !== 13'd2048) begin errors++; $display("FAIL switch_tw got %0d expected 2048", tuning_word_out); end
    endtask

    task automatic test_modes();
        bit found;
        logic [9:0] ea;
        int modes[3];
        int lens[3];
        modes = '{2, 1, 3};
        lens  = '{8, 8, 4};
        tw_override = 13'd1024;
        wait_wrap(64, found);
        checks++; if (!found || tuning_word_out !== 13'd1024) begin
            errors++; $display("FAIL modes_sync got found %b tw %0d expected 1 1024", found, tuning_word_out);
        end
        m_phase = 0; m_active = 1024;
        for (int s = 0; s < 3; s++) begin
            mode = 2'(modes[s]);
            for (int i = 0; i < lens[s]; i++) begin
                model_tick();
                @(negedge clk);
                ea = 10'(amp_q.pop_front());
                void'(wrap_q.pop_front());
                checks++; if (amplitude !== ea) begin errors++; $display("FAIL mode%0d_amp tick %0d got %0d expected %0d", modes[s], i, amplitude, ea); end
            end
        end
        mode = 2'd0;
    endtask

    task automatic test_distance(input logic [11:0] d, input logic [12:0] exp_tw);
        int cnt;
        int t;
        tw_override_en = 1'b0;
        distance = d; distance_valid = 1'b1;
        @(negedge clk);
        distance_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 25) begin errors++; $display("FAIL dist%0d_busy got %0d cycles expected 25", d, cnt); end
        t = 0;
        while (tuning_word_out !== exp_tw && t < 2000) begin
            t++;
            @(negedge clk);
        end
        checks++; if (tuning_word_out !== exp_tw) begin errors++; $display("FAIL dist%0d_tw got %0d expected %0d", d, tuning_word_out, exp_tw); end
        checks++; if (phase_wrap !== 1'b1) begin errors++; $display("FAIL dist%0d_at_wrap got wrap %b expected 1", d, phase_wrap); end
    endtask

    task automatic test_busy_reset_zero();
        int cnt;
        int t;
        bit found;
        logic [9:0] ea;
        // Second strobe while busy is dropped; active word is 16 here.
        tw_override_en = 1'b0;
        distance = 12'd1200; distance_valid = 1'b1;
        @(negedge clk);
        distance_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin distance = 12'd100; distance_valid = 1'b1; end
            else distance_valid = 1'b0;
            @(negedge clk);
        end
        distance_valid = 1'b0;
        checks++; if (cnt != 25) begin errors++; $display("FAIL ignore_busy got %0d cycles expected 25", cnt); end
        t = 0;
        while (tuning_word_out === 13'd16 && t < 2000) begin
            t++;
            @(negedge clk);
        end
        checks++; if (tuning_word_out !== 13'd72) begin errors++; $display("FAIL ignore_tw got %0d expected 72", tuning_word_out); end

        // Reset in the middle of a divide.
        distance = 12'd100; distance_valid = 1'b1;
        @(negedge clk);
        distance_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || tuning_word_out !== 13'd16) begin
            errors++; $display("FAIL div_reset got busy %b tw %0d expected 0 16", busy, tuning_word_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (busy !== 1'b0 || tuning_word_out !== 13'd16) begin
            errors++; $display("FAIL div_abort got busy %b tw %0d expected 0 16", busy, tuning_word_out);
        end

        // Zero active word is replaced on the very next tick.
        tw_override_en = 1'b1; tw_override = 13'd0;
        wait_wrap(700, found);
        checks++; if (!found || tuning_word_out !== 13'd0) begin
            errors++; $display("FAIL zero_load got found %b tw %0d expected 1 0", found, tuning_word_out);
        end
        m_phase = 0; m_active = 0;
        tw_override = 13'd1024;
        for (int i = 0; i < 4; i++) begin
            model_tick();
            @(negedge clk);
            ea = 10'(amp_q.pop_front());
            void'(wrap_q.pop_front());
            checks++; if (amplitude !== ea) begin errors++; $display("FAIL zero_amp tick %0d got %0d expected %0d", i, amplitude, ea); end
            if (i == 0) begin
                checks++; if (tuning_word_out !== 13'd1024) begin errors++; $display("FAIL zero_next_tick got %0d expected 1024", tuning_word_out); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sawtooth();
        test_div4();
        test_override_switch();
        test_modes();
        test_distance(12'd1200, 13'd72);
        test_distance(12'd100, 13'd128);
        test_distance(12'd4000, 13'd16);
        test_busy_reset_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
